// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and drain handshakes of the instruction encoder
interface instr_encoder_if #(
   parameter int CNT_W = 16
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [2:0]       class_i;
   logic [5:0]       funct_i;
   logic [4:0]       rs_i;
   logic [4:0]       rt_i;
   logic [4:0]       rd_i;
   logic [15:0]      imm_i;
   logic [31:0]      instr_o;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [CNT_W-1:0] count_o;
   logic             err_o;
   modport master (
      output in_valid_i, class_i, funct_i, rs_i, rt_i, rd_i, imm_i, out_ready_i,
      input  in_ready_o, instr_o, out_valid_o, count_o, err_o
   );
   modport slave (
      input  in_valid_i, class_i, funct_i, rs_i, rt_i, rd_i, imm_i, out_ready_i,
      output in_ready_o, instr_o, out_valid_o, count_o, err_o
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes addi/slti/R-format/beq requests into a FIFO-buffered MIPS word stream; define ENC_BYPASS_EN for zero-latency pass-through when the FIFO is empty
module instr_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic            clk_i,
   input logic            rst_i,
   instr_encoder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [31:0]      mem [DEPTH];
   logic [31:0]      word;
   logic [5:0]       op;
   logic             legal, full, empty, accept, push, pop, bypass, take, err;
   logic [CNT_W-1:0] count;
   // Encode the request and decide whether it is a supported instruction
   always_comb begin
      op    = bus.class_i == 3'd0 ? 6'b001000 :
              bus.class_i == 3'd1 ? 6'b001010 :
              bus.class_i == 3'd3 ? 6'b000100 : 6'b000000;
      word  = bus.class_i == 3'd2 ? {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'b00000, bus.funct_i}
                                  : {op, bus.rs_i, bus.rt_i, bus.imm_i};
      legal = bus.class_i inside {3'd0, 3'd1, 3'd3} ||
              (bus.class_i == 3'd2 && bus.funct_i inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
   end
   assign empty  = wr_ptr == rd_ptr;
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign accept = bus.in_valid_i && !full;
`ifdef ENC_BYPASS_EN
   assign bypass = empty && accept && bus.out_ready_i && legal;
`else
   assign bypass = 1'b0;
`endif
   assign push            = accept && legal && !bypass;
   assign pop             = !empty && bus.out_ready_i;
   assign take            = pop || bypass;
   assign bus.in_ready_o  = !full;
   assign bus.out_valid_o = !empty || bypass;
   assign bus.instr_o     = !empty ? mem[rd_ptr[AW-1:0]] : bypass ? word : 32'd0;
   assign bus.count_o     = count;
   assign bus.err_o       = err;
   // Pointers, handed-out counter and sticky illegal-request flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (take) count <= count + CNT_W'(1);
         if (accept && !legal) err <= 1'b1;
      end
   end
   // Word storage; stale contents are masked by the empty check on read
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= word;
   end
endmodule
